// File: rtl/key_filter_bank.sv
// Bank of independent key debouncers: 2-flop sync, per-key stability counter, press pulse and sticky flag.
// Defining KEY_FILTER_RELEASE_EN adds one-cycle release pulses; otherwise key_release is tied low.
module key_filter_bank #(
    parameter int N_KEYS          = 8,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [N_KEYS-1:0] key_in,
    input  logic [N_KEYS-1:0] ack,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_sticky
);
    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [N_KEYS-1:0] sync1_q;
    logic [N_KEYS-1:0] sync2_q;
    logic [N_KEYS-1:0] level_q;
    logic [N_KEYS-1:0] level_d;
    logic [N_KEYS-1:0] press_q;
    logic [N_KEYS-1:0] press_d;
    logic [N_KEYS-1:0] sticky_q;
    logic [N_KEYS-1:0] sticky_d;
    logic [N_KEYS-1:0] toggle;
    logic [N_KEYS-1:0] pressed_s;
    logic [CNT_W-1:0]  cnt_q [N_KEYS];
    logic [CNT_W-1:0]  cnt_d [N_KEYS];

    // Pins are active-low; after synchronisation 1 means pressed.
    assign pressed_s = ~sync2_q;

    always_comb begin
        toggle = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            cnt_d[i] = '0;
            if (pressed_s[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    toggle[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
        level_d  = level_q ^ toggle;
        press_d  = toggle & ~level_q;
        // A press in the current cycle overrides a simultaneous acknowledge.
        sticky_d = press_d | (sticky_q & ~(ack & ~press_q));
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q  <= '1;
            sync2_q  <= '1;
            level_q  <= '0;
            press_q  <= '0;
            sticky_q <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= key_in;
            sync2_q  <= sync1_q;
            level_q  <= level_d;
            press_q  <= press_d;
            sticky_q <= sticky_d;
            for (int i = 0; i < N_KEYS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef KEY_FILTER_RELEASE_EN
    logic [N_KEYS-1:0] release_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            release_q <= '0;
        end else begin
            release_q <= toggle & level_q;
        end
    end

    assign key_release = release_q;
`else
    assign key_release = '0;
`endif

    assign key_level  = level_q;
    assign key_press  = press_q;
    assign key_sticky = sticky_q;
endmodule

// File: doc/key_filter_bank.md
KEY_FILTER_BANK -- requirements
Module: key_filter_bank

Interface
REQ-001 The block SHALL have parameter N_KEYS, default 8, meaning the number of independent key channels (1..8).
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning the stable-input cycles required before an accepted change (20 ms at 50 MHz); legal range is 2..2^24.
REQ-003 The block SHALL have the port sys_clk, input, 1 bit: the single clock, on the board oscillator domain.
REQ-004 The block SHALL have the port sys_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have the port key_in, input, N_KEYS bits: raw asynchronous key pins, active-low (0 = pressed).
REQ-006 The block SHALL have the port ack, input, N_KEYS bits: a per-bit clear for key_sticky, sampled each cycle.
REQ-007 The block SHALL have the port key_level, output, N_KEYS bits: debounced state (1 = pressed), driving the PIO input bus.
REQ-008 The block SHALL have the port key_press, output, N_KEYS bits: a one-cycle pulse on each accepted press.
REQ-009 The block SHALL have the port key_release, output, N_KEYS bits: a one-cycle pulse on each accepted release (see Configuration).
REQ-010 The block SHALL have the port key_sticky, output, N_KEYS bits: a latched press flag held until it is acknowledged.

Function
REQ-011 Each key_in bit SHALL pass through a 2-flop synchronizer, and its inverted output is s[i] (1 = pressed).
REQ-012 Each channel SHALL have its own counter sized to hold DEBOUNCE_CYCLES-1; counters SHALL NOT be shared.
REQ-013 The counter SHALL clear in any cycle where s[i] equals key_level[i].
REQ-014 The counter SHALL increment in any cycle where s[i] differs from key_level[i] and the count is below DEBOUNCE_CYCLES-1.
REQ-015 When s[i] differs from key_level[i] and the count equals DEBOUNCE_CYCLES-1, key_level[i] SHALL toggle on that edge and the counter SHALL clear.
REQ-016 Latency SHALL be as follows: a clean key_in edge, set up before clock edge 1, changes key_level on edge DEBOUNCE_CYCLES+2.
REQ-017 A glitch lasting fewer than DEBOUNCE_CYCLES synchronized cycles SHALL leave key_level unchanged and SHALL produce no pulses.
REQ-018 key_press[i] SHALL be 1 for exactly the one cycle after the edge on which key_level[i] goes from 0 to 1.
REQ-019 key_press[i] SHALL be registered and coincident with the first cycle of key_level[i]=1.
REQ-020 key_sticky[i] SHALL be set on any cycle in which key_press[i]=1.
REQ-021 key_sticky[i] SHALL clear on the edge after a cycle in which ack[i]=1 and key_press[i]=0.
REQ-022 If key_press[i] and ack[i] are both 1 in the same cycle, the set SHALL win and key_sticky[i] remains 1.
REQ-023 ack held high continuously SHALL keep key_sticky clear except on press cycles, where REQ-022 applies.
REQ-024 Channels SHALL be fully independent: simultaneous events on different channels SHALL all be reported in the same cycle.
REQ-025 No output SHALL depend combinationally on key_in or ack.

Reset
REQ-026 On sys_rst_n=0, asynchronously: synchronizer flops SHALL go to 1 (released), all counters to 0, and key_level, key_press, key_release and key_sticky to all-0.
REQ-027 Reset asserted mid-count or mid-pulse SHALL abort immediately, with no pulse emitted after release.
REQ-028 After reset release, a key held pressed throughout reset SHALL be reported as a fresh press after DEBOUNCE_CYCLES+2 cycles.

Configuration
REQ-029 The feature SHALL be controlled by the macro KEY_FILTER_RELEASE_EN.
REQ-030 With KEY_FILTER_RELEASE_EN defined, key_release[i] SHALL be 1 for exactly one cycle coincident with the first cycle of key_level[i]=0 following a 1.
REQ-031 Without KEY_FILTER_RELEASE_EN, key_release SHALL be tied to all-0, its pulse logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification (DEBOUNCE_CYCLES=16, N_KEYS=8)
REQ-032 The bench SHALL cover a clean press: key_in[0] 1->0 before edge 1 -> key_level[0]=1 and key_press[0]=1 on edge 18 only; key_sticky[0]=1 from edge 18.
REQ-033 The bench SHALL cover a glitch: key_in[3] low for 10 cycles then high -> key_level, key_press and key_sticky stay 0x00 for 40 cycles.
REQ-034 The bench SHALL cover bounce then settle: key_in[1] toggles every 5 cycles for 30 cycles then stays low -> exactly one key_press[1] pulse, 18 edges after the last toggle.
REQ-035 The bench SHALL cover an ack collision: ack[0]=1 in the same cycle as key_press[0]=1 -> key_sticky[0] stays 1; ack[0]=1 one cycle later -> key_sticky[0]=0.
REQ-036 The bench SHALL cover release with KEY_FILTER_RELEASE_EN defined: the key released after a press -> key_release[0] single pulse 18 edges later; with the macro undefined, key_release=0x00 throughout.
REQ-037 The bench SHALL cover reset mid-count: sys_rst_n pulsed low at count 10 with key_in[2] held low -> all outputs 0 immediately; key_press[2] fires on edge 18 after release.
